// File: rtl/regfile_wb_arbiter_if.sv
// Signal bundle for regfile_wb_arbiter: the two writeback source handshakes,
// the register-file write port, and the hazard-facing status outputs.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic                 s0_valid;
  logic [AW-1:0]        s0_rd;
  logic [XLEN-1:0]      s0_data;
  logic                 s0_ready;

  logic                 s1_valid;
  logic [AW-1:0]        s1_rd;
  logic [XLEN-1:0]      s1_data;
  logic                 s1_ready;

  logic                 RegWrite;
  logic [AW-1:0]        Rd;
  logic [XLEN-1:0]      Write_data;

  logic [(2**AW)-1:0]   busy_mask;
  logic                 idle;

  // The producing side: execute/load units plus whoever watches the write port.
  modport master (
    output s0_valid, s0_rd, s0_data,
    output s1_valid, s1_rd, s1_data,
    input  s0_ready, s1_ready,
    input  RegWrite, Rd, Write_data,
    input  busy_mask, idle
  );

  // The arbiter side.
  modport slave (
    input  s0_valid, s0_rd, s0_data,
    input  s1_valid, s1_rd, s1_data,
    output s0_ready, s1_ready,
    output RegWrite, Rd, Write_data,
    output busy_mask, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (src0) and load (src1) writeback FIFOs. Optional macro WB_STATS_EN adds stall counters.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave wb
`ifdef WB_STATS_EN
  ,
  output logic [15:0]         stall0_cnt,
  output logic [15:0]         stall1_cnt
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } entry_t;

  // Round-robin pointer names the source that wins the next contended cycle.
  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

  logic [1:0]      src_valid;
  logic [1:0]      src_ready;
  logic [1:0]      nonempty;
  logic [1:0]      push;
  logic [1:0]      pop;
  entry_t          in_entry [2];

  entry_t          mem_q    [2][DEPTH];
  entry_t          mem_d    [2][DEPTH];
  logic [PW-1:0]   wptr_q   [2];
  logic [PW-1:0]   wptr_d   [2];
  logic [PW-1:0]   rptr_q   [2];
  logic [PW-1:0]   rptr_d   [2];
  logic [CW-1:0]   count_q  [2];
  logic [CW-1:0]   count_d  [2];

  src_e            rr_ptr_q;
  src_e            rr_ptr_d;
  src_e            grant;
  logic            grant_vld;
  entry_t          head;

  logic            reg_write_q;
  logic            reg_write_d;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   rd_d;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wdata_d;

  logic [NREG-1:0] busy;

  assign src_valid   = {wb.s1_valid, wb.s0_valid};
  assign in_entry[0] = '{rd: wb.s0_rd, data: wb.s0_data};
  assign in_entry[1] = '{rd: wb.s1_rd, data: wb.s1_data};

  // Ready depends only on occupancy. Writes to x0 complete the handshake but
  // are dropped here, so they never occupy a slot or reach the write port.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    src_ready = '0;
    nonempty  = '0;
    push      = '0;
    for (int s = 0; s < 2; s++) begin
      src_ready[s] = count_q[s] < CW'(DEPTH);
      nonempty[s]  = count_q[s] != '0;
      push[s]      = src_valid[s] && src_ready[s] && (in_entry[s].rd != '0);
    end
  end

  // A lone non-empty FIFO always wins; under contention the pointer decides.
  // The pointer then moves to the source that was not just granted.
  always_comb begin
    grant     = rr_ptr_q;
    grant_vld = |nonempty;
    rr_ptr_d  = rr_ptr_q;
    pop       = '0;
    case (nonempty)
      2'b01:   grant = SRC0;
      2'b10:   grant = SRC1;
      default: grant = rr_ptr_q;
    endcase
    if (grant_vld) begin
      pop      = (grant == SRC1) ? 2'b10 : 2'b01;
      rr_ptr_d = (grant == SRC1) ? SRC0 : SRC1;
    end
  end

  assign head = (grant == SRC1) ? mem_q[1][rptr_q[1]] : mem_q[0][rptr_q[0]];

  // Circular FIFOs; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < 2; s++) begin
      wptr_d[s]  = wptr_q[s];
      rptr_d[s]  = rptr_q[s];
      count_d[s] = count_q[s] + CW'(push[s]) - CW'(pop[s]);
      if (push[s]) begin
        mem_d[s][wptr_q[s]] = in_entry[s];
        wptr_d[s]           = wptr_q[s] + 1'b1;
      end
      if (pop[s]) begin
        rptr_d[s] = rptr_q[s] + 1'b1;
      end
    end
  end

  // Write stage: address and data hold between writes; only the strobe drops.
  always_comb begin
    reg_write_d = grant_vld;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    if (grant_vld) begin
      rd_d    = head.rd;
      wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s]  <= '0;
        rptr_q[s]  <= '0;
        count_q[s] <= '0;
      end
      rr_ptr_q    <= SRC0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s]  <= wptr_d[s];
        rptr_q[s]  <= rptr_d[s];
        count_q[s] <= count_d[s];
      end
      rr_ptr_q    <= rr_ptr_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the counts gate every read,
  // so stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pending-destination mask for hazard detection: live FIFO slots plus the
  // write stage while it is strobing.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = '0;
    busy = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rptr_q[s] + PW'(k);
        if (CW'(k) < count_q[s]) begin
          busy[mem_q[s][idx].rd] = 1'b1;
        end
      end
    end
    if (reg_write_q) begin
      busy[rd_q] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign wb.s0_ready   = src_ready[0];
  assign wb.s1_ready   = src_ready[1];
  assign wb.RegWrite   = reg_write_q;
  assign wb.Rd         = rd_q;
  assign wb.Write_data = wdata_q;
  assign wb.busy_mask  = busy;
  assign wb.idle       = (count_q[0] == '0) && (count_q[1] == '0) && !reg_write_q;

`ifdef WB_STATS_EN
  logic [15:0] stall_q [2];
  logic [15:0] stall_d [2];

  // Saturating count of edges where a source was held off by a full FIFO.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      stall_d[s] = stall_q[s];
      if (src_valid[s] && !src_ready[s] && (stall_q[s] != 16'hFFFF)) begin
        stall_d[s] = stall_q[s] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q[0] <= '0;
      stall_q[1] <= '0;
    end else begin
      stall_q[0] <= stall_d[0];
      stall_q[1] <= stall_d[1];
    end
  end

  assign stall0_cnt = stall_q[0];
  assign stall1_cnt = stall_q[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the writeback rules.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) wb_if ();

`ifdef WB_STATS_EN
  logic [15:0] stall0_cnt;
  logic [15:0] stall1_cnt;
`endif

  regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb         (wb_if)
`ifdef WB_STATS_EN
    ,
    .stall0_cnt (stall0_cnt),
    .stall1_cnt (stall1_cnt)
`endif
  );

  // Reference model: one queue per source, a "src1 wins next tie" flag and
  // the write-port contents after the most recent edge.
  ent_t            q0[$];
  ent_t            q1[$];
  bit              pref1;
  bit              m_we;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;
  bit              m_acc0;
  bit              m_acc1;
  int              st0;
  int              st1;

  bit              pv0;
  bit              pv1;
  int              idx0;
  int              idx1;
  int              nwr;
  bit              saw_stall;
  logic [AW-1:0]   s1_seen[$];

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    pref1  = 1'b0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    st0    = 0;
    st1    = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    bit r0 = q0.size() < DEPTH;
    bit r1 = q1.size() < DEPTH;
    bit v0 = wb_if.s0_valid;
    bit v1 = wb_if.s1_valid;
    int g  = -1;
    if (q0.size() > 0 && q1.size() > 0) g = pref1 ? 1 : 0;
    else if (q0.size() > 0)             g = 0;
    else if (q1.size() > 0)             g = 1;
    m_we = (g >= 0);
    if (g == 0) begin
      m_rd   = q0[0].rd;
      m_data = q0[0].data;
      void'(q0.pop_front());
      pref1  = 1'b1;
    end else if (g == 1) begin
      m_rd   = q1[0].rd;
      m_data = q1[0].data;
      void'(q1.pop_front());
      pref1  = 1'b0;
    end
    m_acc0 = v0 && r0;
    m_acc1 = v1 && r1;
    if (m_acc0 && wb_if.s0_rd != 0) q0.push_back('{rd: wb_if.s0_rd, data: wb_if.s0_data});
    if (m_acc1 && wb_if.s1_rd != 0) q1.push_back('{rd: wb_if.s1_rd, data: wb_if.s1_data});
    if (v0 && !r0 && st0 < 65535) st0++;
    if (v1 && !r1 && st1 < 65535) st1++;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] b;
    b = '0;
    foreach (q0[i]) b[q0[i].rd] = 1'b1;
    foreach (q1[i]) b[q1[i].rd] = 1'b1;
    if (m_we) b[m_rd] = 1'b1;
    check({tag, ".we"},    64'(wb_if.RegWrite),   64'(m_we));
    check({tag, ".rd"},    64'(wb_if.Rd),         64'(m_rd));
    check({tag, ".data"},  64'(wb_if.Write_data), 64'(m_data));
    check({tag, ".busy"},  64'(wb_if.busy_mask),  64'(b));
    check({tag, ".rdy0"},  64'(wb_if.s0_ready),   64'(q0.size() < DEPTH));
    check({tag, ".rdy1"},  64'(wb_if.s1_ready),   64'(q1.size() < DEPTH));
    check({tag, ".idle"},  64'(wb_if.idle),       64'(q0.size() == 0 && q1.size() == 0 && !m_we));
`ifdef WB_STATS_EN
    check({tag, ".st0"},   64'(stall0_cnt),       64'(st0));
    check({tag, ".st1"},   64'(stall1_cnt),       64'(st1));
`endif
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  task automatic drive(input bit v0, input int rd0, input int d0,
                       input bit v1, input int rd1, input int d1);
    wb_if.s0_valid = v0;
    wb_if.s0_rd    = AW'(rd0);
    wb_if.s0_data  = XLEN'(d0);
    wb_if.s1_valid = v1;
    wb_if.s1_rd    = AW'(rd1);
    wb_if.s1_data  = XLEN'(d1);
  endtask

  function automatic logic [AW-1:0] rand_rd();
    if ($urandom_range(0, 7) == 0) return '0;
    return AW'($urandom_range(1, 31));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    do_reset();

    // Single write: latency and busy-bit lifetime.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    tick("single.k");
    drive(0, 0, 0, 0, 0, 0);
    check("single.k.we",    64'(wb_if.RegWrite),     64'd0);
    check("single.k.busy5", 64'(wb_if.busy_mask[5]), 64'd1);
    tick("single.k1");
    check("single.k1.we",   64'(wb_if.RegWrite),     64'd1);
    check("single.k1.rd",   64'(wb_if.Rd),           64'd5);
    check("single.k1.data", 64'(wb_if.Write_data),   64'hDEADBEEF);
    check("single.k1.busy", 64'(wb_if.busy_mask[5]), 64'd1);
    tick("single.k2");
    check("single.k2.we",   64'(wb_if.RegWrite),     64'd0);
    check("single.k2.busy", 64'(wb_if.busy_mask),    64'd0);
    check("single.k2.idle", 64'(wb_if.idle),         64'd1);

    // Contention: round-robin interleave 1,3,2,4.
    do_reset();
    drive(1, 1, 32'h11, 1, 3, 32'h33);
    tick("cont.e1");
    drive(1, 2, 32'h22, 1, 4, 32'h44);
    tick("cont.e2");
    drive(0, 0, 0, 0, 0, 0);
    check("cont.w1", 64'(wb_if.Rd), 64'd1);
    tick("cont.e3");
    check("cont.w2", 64'(wb_if.Rd), 64'd3);
    tick("cont.e4");
    check("cont.w3", 64'(wb_if.Rd), 64'd2);
    tick("cont.e5");
    check("cont.w4", 64'(wb_if.Rd), 64'd4);
    check("cont.w4.we", 64'(wb_if.RegWrite), 64'd1);
    tick("cont.e6");
    check("cont.idle", 64'(wb_if.idle), 64'd1);

    // Backpressure: src1 pushes three back-to-back while src0 contends.
    do_reset();
    idx0 = 0;
    idx1 = 0;
    saw_stall = 1'b0;
    s1_seen.delete();
    for (int i = 0; i < 16; i++) begin
      drive(idx0 < 6, 20 + idx0, 32'hB000 + idx0, idx1 < 3, 10 + idx1, 32'hA000 + idx1);
      if (wb_if.s1_valid && !wb_if.s1_ready) saw_stall = 1'b1;
      tick("bp");
      if (m_acc0) idx0++;
      if (m_acc1) idx1++;
      if (wb_if.RegWrite && wb_if.Rd >= 10 && wb_if.Rd <= 12) s1_seen.push_back(wb_if.Rd);
    end
    drive(0, 0, 0, 0, 0, 0);
    check("bp.stall_seen", 64'(saw_stall), 64'd1);
    check("bp.s1_writes", 64'(s1_seen.size()), 64'd3);
    if (s1_seen.size() == 3) begin
      check("bp.order0", 64'(s1_seen[0]), 64'd10);
      check("bp.order1", 64'(s1_seen[1]), 64'd11);
      check("bp.order2", 64'(s1_seen[2]), 64'd12);
    end
    tick("bp.drain");
    tick("bp.drain");

    // x0 filter: the rd=0 request is accepted but never written.
    do_reset();
    nwr = 0;
    drive(1, 0, 32'h1234, 0, 0, 0);
    tick("x0.a");
    check("x0.rdy0",  64'(wb_if.s0_ready),     64'd1);
    check("x0.busy0", 64'(wb_if.busy_mask[0]), 64'd0);
    check("x0.idle",  64'(wb_if.idle),         64'd1);
    drive(1, 7, 32'h77, 0, 0, 0);
    tick("x0.b");
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("x0.c");
      if (wb_if.RegWrite) begin
        nwr++;
        check("x0.rd", 64'(wb_if.Rd), 64'd7);
      end
    end
    check("x0.nwrites", 64'(nwr), 64'd1);

    // Reset mid-operation with both queues loaded and a write staged.
    drive(1, 8, 32'h88, 1, 9, 32'h99);
    for (int i = 0; i < 4; i++) tick("mid.fill");
    check("mid.staged", 64'(wb_if.RegWrite), 64'd1);
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    check("mid.we",   64'(wb_if.RegWrite),  64'd0);
    check("mid.busy", 64'(wb_if.busy_mask), 64'd0);
    check("mid.idle", 64'(wb_if.idle),      64'd1);
    check("mid.rdy0", 64'(wb_if.s0_ready),  64'd1);
    check("mid.rdy1", 64'(wb_if.s1_ready),  64'd1);
    for (int i = 0; i < 3; i++) begin
      tick("mid.after");
      check("mid.nostale", 64'(wb_if.RegWrite), 64'd0);
    end

`ifdef WB_STATS_EN
    // Sustained dual-source pressure makes both stall counters advance.
    drive(1, 8, 32'h88, 1, 9, 32'h99);
    for (int i = 0; i < 20; i++) tick("stats");
    check("stats.st0_nz", 64'(stall0_cnt != 0), 64'd1);
    check("stats.st1_nz", 64'(stall1_cnt != 0), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
`endif

    // Random traffic: light load first, then near-saturating load.
    pv0 = 1'b0;
    pv1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      int thr;
      thr = (i < 300) ? 1 : 3;
      if (!pv0 && $urandom_range(0, 3) < thr) begin
        pv0 = 1'b1;
        wb_if.s0_rd   = rand_rd();
        wb_if.s0_data = $urandom();
      end
      if (!pv1 && $urandom_range(0, 3) < thr) begin
        pv1 = 1'b1;
        wb_if.s1_rd   = rand_rd();
        wb_if.s1_data = $urandom();
      end
      wb_if.s0_valid = pv0;
      wb_if.s1_valid = pv1;
      tick("rnd");
      if (m_acc0) pv0 = 1'b0;
      if (m_acc1) pv1 = 1'b0;
    end
    wb_if.s0_valid = 1'b0;
    wb_if.s1_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick("rnd.drain");
    check("rnd.final_idle", 64'(wb_if.idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
